// File: rtl/mmio_bridge.sv
// ============================================================================
// Module   : mmio_bridge
// Brief    : dmem decoder routing RAM accesses and serving a small MMIO block
//            (input-event FIFO, two display registers, free-running counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_bridge #(
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic        mem_advance,
  output logic [31:0] q_dmem,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  input  logic        evt_valid,
  input  logic [7:0]  evt_code,
  output logic        evt_ready,
  output logic [31:0] disp0,
  output logic [31:0] disp1
);

  localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  c_DEPTH = 5'(FIFO_DEPTH);

  localparam logic [31:0] c_OFF_STATUS = 32'd0;
  localparam logic [31:0] c_OFF_EVENT  = 32'd1;
  localparam logic [31:0] c_OFF_DISP0  = 32'd2;
  localparam logic [31:0] c_OFF_DISP1  = 32'd3;
  localparam logic [31:0] c_OFF_CYCLES = 32'd4;

  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [4:0]         r_count;
  logic               r_overflow;
  logic [31:0]        r_disp0;
  logic [31:0]        r_disp1;
  logic [31:0]        r_cycles;

  logic        w_is_mmio;
  logic [31:0] w_offset;
  logic        w_full;
  logic        w_empty;
  logic        w_mmio_rd;
  logic        w_mmio_wr;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic [31:0] w_mmio_q;

  assign w_is_mmio = (address_dmem >= MMIO_BASE);
  assign w_offset  = address_dmem - MMIO_BASE;
  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == 5'd0);

  // All MMIO side effects are qualified by mem_advance so a stalled access acts once.
  assign w_mmio_rd = ~wren & w_is_mmio & mem_advance;
  assign w_mmio_wr =  wren & w_is_mmio & mem_advance;

  assign w_pop     = w_mmio_rd & (w_offset == c_OFF_EVENT) & ~w_empty;
  // A pop frees the slot at the same edge, so a push while full still lands.
  assign w_push    = evt_valid & (~w_full | w_pop);
  assign w_ovf_set = evt_valid & w_full & ~w_pop;
  assign w_ovf_clr = w_mmio_rd & (w_offset == c_OFF_STATUS);

  assign ram_addr  = address_dmem;
  assign ram_data  = data;
  assign ram_wren  = wren & ~w_is_mmio;
  assign evt_ready = ~w_full;
  assign disp0     = r_disp0;
  assign disp1     = r_disp1;

  always_comb begin
    w_mmio_q = 32'b0;
    case (w_offset)
      c_OFF_STATUS: w_mmio_q = {26'b0, r_overflow, r_count};
      c_OFF_EVENT:  w_mmio_q = w_empty ? 32'b0 : {24'b0, r_fifo[r_head]};
      c_OFF_DISP0:  w_mmio_q = r_disp0;
      c_OFF_DISP1:  w_mmio_q = r_disp1;
      c_OFF_CYCLES: w_mmio_q = r_cycles;
      default:      w_mmio_q = 32'b0;
    endcase
  end

  assign q_dmem = w_is_mmio ? w_mmio_q : ram_q;

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_tail] <= evt_code;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_disp0  <= 32'b0;
      r_disp1  <= 32'b0;
      r_cycles <= 32'b0;
    end else begin
      if (w_mmio_wr && (w_offset == c_OFF_DISP0)) begin
        r_disp0 <= data;
      end
      if (w_mmio_wr && (w_offset == c_OFF_DISP1)) begin
        r_disp1 <= data;
      end
      if (w_mmio_wr && (w_offset == c_OFF_CYCLES)) begin
        r_cycles <= data;
      end else begin
        r_cycles <= r_cycles + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the processor's dmem port and the data RAM/peripherals.
- Decodes each data-memory access. RAM addresses pass through to RAM. MMIO addresses hit a small register file: an input-event FIFO fed by the controller/button front end, two display registers and a cycle counter.
- Gives the checkers game loop a way to poll moves and drive the board display with ordinary lw/sw.

Parameters:
- MMIO_BASE, 32'h0000_1000, first MMIO word address; addresses >= MMIO_BASE are MMIO, below are RAM.
- FIFO_DEPTH, 8, event FIFO entries (power of two, 2..16).

Ports:
- clock  in  1  master clock
- reset  in  1  asynchronous, active-high reset
- address_dmem  in  32  processor data address (M stage)
- data  in  32  processor store data
- wren  in  1  processor store enable
- mem_advance  in  1  high when the M-stage instruction retires to W at the next rising edge (processor ~stall)
- q_dmem  out  32  read data returned to processor
- ram_addr  out  32  RAM address (= address_dmem)
- ram_data  out  32  RAM write data (= data)
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM read data
- evt_valid  in  1  input event strobe
- evt_code  in  8  input event code
- evt_ready  out  1  FIFO not full
- disp0  out  32  display register 0
- disp1  out  32  display register 1

Behaviour:
- Decode: is_mmio = (address_dmem >= MMIO_BASE), unsigned compare. ram_wren = wren & ~is_mmio. RAM writes are idempotent, so they are not gated by mem_advance.
- q_dmem is combinational. If ~is_mmio, q_dmem = ram_q. Otherwise it is the MMIO read value for the register at offset address_dmem - MMIO_BASE.
- MMIO read map:
  - +0 STATUS = {26'b0, overflow, count[4:0]}; count is 0..FIFO_DEPTH.
  - +1 EVENT = {24'b0, head code} if count != 0, else 32'b0.
  - +2 DISP0.
  - +3 DISP1.
  - +4 CYCLES.
  - All other offsets read 32'b0.
- Side effects occur only at a rising edge with mem_advance = 1. Repeated cycles of a stalled lw/sw therefore act exactly once.
  - Pop: ~wren & is_mmio & offset==1 & count!=0 & mem_advance. The head advances at that same edge, after the processor has captured q_dmem.
  - STATUS read with mem_advance clears overflow at that edge. If an overflow event occurs at the same edge, overflow stays 1.
  - Write: wren & is_mmio & mem_advance.
    - Offset 2 loads disp0; offset 3 loads disp1.
    - Offset 4 loads CYCLES with data. The write takes priority over increment; the next cycle counts from the written value.
    - Writes to offsets 0, 1 and unmapped offsets are ignored.
- CYCLES: 32-bit free-running; +1 every clock; wraps 32'hFFFF_FFFF -> 0.
- Event FIFO: circular buffer with head pointer, tail pointer and count.
  - Push when evt_valid & count<FIFO_DEPTH.
  - evt_valid while full: the event is dropped and overflow is set to 1 (sticky).
  - evt_ready = (count < FIFO_DEPTH), combinational.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Pop when empty is a no-op; a push in the same cycle still occurs (count 0->1).
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous, any time, including mid-access): all of the following clear immediately, not at the next edge:
  - head = tail = count = 0, overflow = 0
  - disp0 = disp1 = 0, CYCLES = 0
  - evt_ready = 1
  - q_dmem reflects the cleared state combinationally
  - FIFO contents need not be cleared
- No additional latency is added to RAM or MMIO reads; the processor's existing capture timing is unchanged.

Test Plan:
- Reset then idle: disp0=disp1=0, evt_ready=1; lw 0x1000 returns 0; lw 0x1004 three cycles after reset release returns 3 (±1 per sample edge; bench checks a difference of consecutive reads equals the spacing).
- RAM passthrough: sw 0x0000_0010 with data 0xDEADBEEF -> ram_wren=1, ram_addr=0x10, ram_data=0xDEADBEEF. With ram_q=0x1234, lw 0x10 gives q_dmem=0x1234. No MMIO register changes.
- FIFO order: push codes 0x11, 0x22, 0x33; STATUS=3. Three lw 0x1001 with mem_advance=1 return 0x11, 0x22, 0x33; STATUS then 0; a fourth EVENT read returns 0 and count stays 0.
- Stall safety: push 0x55, 0x66; hold lw 0x1001 for 4 cycles with mem_advance=0, then 1 cycle with mem_advance=1 -> q_dmem=0x55 throughout and exactly one pop; next EVENT read = 0x66.
- Full/overflow: push 9 events with FIFO_DEPTH=8 -> evt_ready=0 after the 8th, STATUS=0x28. Reading STATUS with advance clears overflow (next STATUS=0x08). Push+pop on the same edge while full keeps count=8 and overflow=0.
- Writes and reset: sw 0x1002 with 0xA5A5A5A5 held for 3 stalled cycles then advance -> disp0=0xA5A5A5A5. sw 0x1004 with 0xFFFFFFFF -> CYCLES reads 0 one cycle later (wrap). Assert reset mid-stream -> all outputs cleared without waiting for a clock edge.
